// File: rtl/sete_segmentos_para_bcd.sv
// Recovers a 4-digit BCD frame from a multiplexed active-low 7-segment display bus.
// A strobed sample that completes a frame shows on bcd_valor/bcd_valido one cycle later.
module sete_segmentos_para_bcd #(
    parameter int ESTAVEL = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  segmentos,
    input  logic [3:0]  digito_en,
    input  logic        amostra_en,
    output logic [15:0] bcd_valor,
    output logic        bcd_valido,
    output logic        erro_padrao,
    output logic        erro_colisao
);

    localparam logic [2:0] LIMIAR = 3'(ESTAVEL);

    logic [3:0][6:0] ultimo_q, ultimo_d;
    logic [3:0][2:0] cont_q,   cont_d;
    logic [3:0][3:0] dig_q,    dig_d;
    logic [3:0]      mask_q,   mask_d;
    logic [15:0]     bcd_valor_q,    bcd_valor_d;
    logic            bcd_valido_q,   bcd_valido_d;
    logic            erro_padrao_q,  erro_padrao_d;
    logic            erro_colisao_q, erro_colisao_d;

    logic [3:0] sel;
    logic [2:0] n_ativos;
    logic [1:0] idx;
    logic       aceita;
    logic       colisao;
    logic [2:0] cont_novo;
    logic [3:0] nibble;
    logic [3:0] commit_vec;
    logic       quadro_ok;

    function automatic logic [3:0] decodifica(input logic [6:0] p);
        logic [3:0] n;
        case (p)
            7'b0000001: n = 4'h0;
            7'b1001111: n = 4'h1;
            7'b0010010: n = 4'h2;
            7'b0000110: n = 4'h3;
            7'b1001100: n = 4'h4;
            7'b0100100: n = 4'h5;
            7'b1100000: n = 4'h6;
            7'b0001111: n = 4'h7;
            7'b0000000: n = 4'h8;
            7'b0001100: n = 4'h9;
            7'b1111111: n = 4'hF;
            default:    n = 4'hE;
        endcase
        return n;
    endfunction

    always_comb begin
        sel      = ~digito_en;
        n_ativos = 3'd0;
        idx      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                n_ativos = n_ativos + 3'd1;
                idx      = 2'(i);
            end
        end
        aceita  = amostra_en && (n_ativos == 3'd1);
        colisao = amostra_en && (n_ativos > 3'd1);

        // Counter saturates at 7 so a long-held digit keeps recommitting.
        if (segmentos == ultimo_q[idx])
            cont_novo = (cont_q[idx] == 3'd7) ? 3'd7 : cont_q[idx] + 3'd1;
        else
            cont_novo = 3'd1;

        nibble     = decodifica(segmentos);
        commit_vec = 4'b0000;
        if (aceita && (cont_novo >= LIMIAR))
            commit_vec[idx] = 1'b1;

        ultimo_d = ultimo_q;
        cont_d   = cont_q;
        dig_d    = dig_q;
        if (aceita) begin
            ultimo_d[idx] = segmentos;
            cont_d[idx]   = cont_novo;
            if (commit_vec[idx])
                dig_d[idx] = nibble;
        end

        // The digit committed at this edge already counts toward the frame.
        quadro_ok      = ((mask_q | commit_vec) == 4'b1111);
        mask_d         = quadro_ok ? 4'b0000 : (mask_q | commit_vec);
        bcd_valor_d    = quadro_ok ? {dig_d[3], dig_d[2], dig_d[1], dig_d[0]} : bcd_valor_q;
        bcd_valido_d   = quadro_ok;
        erro_padrao_d  = (|commit_vec) && (nibble == 4'hE);
        erro_colisao_d = erro_colisao_q | colisao;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ultimo_q       <= {4{7'b1111111}};
            cont_q         <= '0;
            dig_q          <= {4{4'hF}};
            mask_q         <= 4'b0000;
            bcd_valor_q    <= 16'hFFFF;
            bcd_valido_q   <= 1'b0;
            erro_padrao_q  <= 1'b0;
            erro_colisao_q <= 1'b0;
        end else begin
            ultimo_q       <= ultimo_d;
            cont_q         <= cont_d;
            dig_q          <= dig_d;
            mask_q         <= mask_d;
            bcd_valor_q    <= bcd_valor_d;
            bcd_valido_q   <= bcd_valido_d;
            erro_padrao_q  <= erro_padrao_d;
            erro_colisao_q <= erro_colisao_d;
        end
    end

    assign bcd_valor    = bcd_valor_q;
    assign bcd_valido   = bcd_valido_q;
    assign erro_padrao  = erro_padrao_q;
    assign erro_colisao = erro_colisao_q;

endmodule

// File: doc/sete_segmentos_para_bcd.md
SETE_SEGMENTOS_PARA_BCD -- requirements
Module: sete_segmentos_para_bcd

Interface
REQ-001 Parameter: ESTAVEL, default 3, number of consecutive identical accepted samples of a digit before that digit is committed; legal range 1..7.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 segmentos  input  7  sampled segment lines, bit order {a,b,c,d,e,f,g} = [6:0]; active-low, 0 = segment lit.
REQ-005 digito_en  input  4  digit enables, active-low; bit i low = digit i driven; bit 0 = least significant digit.
REQ-006 amostra_en  input  1  sample strobe; segmentos/digito_en are evaluated only in cycles where it is 1.
REQ-007 bcd_valor  output  16  last complete frame; nibble i = digit i.
REQ-008 bcd_valido  output  1  one-cycle pulse marking a new bcd_valor.
REQ-009 erro_padrao  output  1  one-cycle pulse when a committed pattern is not in the decode table.
REQ-010 erro_colisao  output  1  sticky flag: a strobed sample had more than one digit enabled.

Function
REQ-011 Decode table, active-low pattern -> nibble: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 1100000->6, 0001111->7, 0000000->8, 0001100->9, 1111111->F (blank); any other pattern -> E (invalid).
REQ-012 Accepted sample: amostra_en=1 and digito_en has exactly one 0 bit; that bit index is the target digit i.
REQ-013 digito_en=4'b1111 with amostra_en=1: sample ignored, no state change, no error.
REQ-014 Two or more digito_en bits low with amostra_en=1: sample ignored for decoding; erro_colisao set to 1 at the next edge and held until reset.
REQ-015 Per digit i, state: last pattern ultimo[i] (7 bits) and saturating counter cont[i] (3 bits, saturates at 7).
REQ-016 Accepted sample, pattern equal to ultimo[i]: cont[i] incremented (saturating); otherwise ultimo[i] <= pattern and cont[i] <= 1.
REQ-017 Commit: when the post-update cont[i] >= ESTAVEL, digit register dig[i] <= decoded nibble and frame mask bit mask[i] <= 1 at the same edge; this repeats on every further stable sample.
REQ-018 With ESTAVEL=1, every accepted sample commits.
REQ-019 erro_padrao = 1 in the cycle following an edge that committed nibble E; otherwise 0.
REQ-020 Frame completion: if at an edge (mask OR commit bit) = 4'b1111, then at that edge bcd_valor <= {dig[3],dig[2],dig[1],dig[0]} including the digit just committed, bcd_valido <= 1, and mask <= 0.
REQ-021 bcd_valido is 0 in every cycle not following a frame-completion edge; never high two cycles in a row.
REQ-022 bcd_valor is held between frames; a frame is emitted even if identical to the previous frame.
REQ-023 Latency: strobed sample in cycle N completing a frame -> bcd_valor/bcd_valido visible in cycle N+1.
REQ-024 Digits unsampled since the last frame block completion; a frame never contains a digit not recommitted since the previous frame.

Reset
REQ-025 reset=1 at an edge: bcd_valor <= 16'hFFFF, bcd_valido <= 0, erro_padrao <= 0, erro_colisao <= 0, all dig[i] <= F, ultimo[i] <= 7'b1111111, cont[i] <= 0, mask <= 0.
REQ-026 reset has priority over any simultaneous sample; a partially assembled frame is discarded.
REQ-027 Outputs stay at reset values until the first frame completion after reset is released.

Verification
REQ-028 ESTAVEL=3; strobe digits 0..3 round-robin with patterns for 1,2,3,4, three rounds -> single bcd_valido pulse one cycle after third strobe of digit 3, bcd_valor=16'h4321.
REQ-029 Digit 2 pattern alternates 0010010/0000110 each round, others stable -> no bcd_valido; after fixing digit 2 to 0100100 for 3 rounds -> bcd_valor nibble 2 = 5.
REQ-030 digito_en=4'b1100 with amostra_en=1 -> erro_colisao=1 from next cycle, remains 1; no counter/mask change; cleared only by reset.
REQ-031 Digit 1 stable pattern 1111110 for 3 samples -> erro_padrao pulse 1 cycle; subsequent frame nibble 1 = E; all-blank pattern yields nibble F, no error.
REQ-032 Reset asserted after digits 0..2 committed, before digit 3 -> bcd_valor=16'hFFFF, no bcd_valido; full new frame required afterwards.
